// File: rtl/mem_stage.sv
// MIPS MEM stage: width-aware loads/stores over a req/ack data memory, branch resolution, MEM/WB register.
// Defining MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and adds the MisalignOut flag.
module mem_stage (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        R_EnableIn,
    input  logic        W_EnableIn,
    input  logic [1:0]  R_WidthIn,
    input  logic [1:0]  W_WidthIn,
    input  logic [3:0]  BranchSelIn,
    input  logic        ZeroIn,
    input  logic        RegWriteIn,
    input  logic        MemToRegIn,
    input  logic [31:0] ALUResultIn,
    input  logic [31:0] RegData2In,
    input  logic [4:0]  rDestSelectedIn,
    input  logic [31:0] PCPlusBranchIn,
    input  logic [27:0] jumpLeftShiftedTwoIn,
    output logic [31:0] DMemAddr,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemWData,
    output logic [3:0]  DMemByteEn,
    input  logic [31:0] DMemRData,
    input  logic        DMemAck,
    output logic        Stall,
    output logic        PCSrcOut,
    output logic [31:0] BranchTargetOut,
    output logic [31:0] ReadDataOut,
    output logic [31:0] ALUResultOut,
    output logic [4:0]  rDestSelectedOut,
    output logic        RegWriteOut,
    output logic        MemToRegOut
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        MisalignOut
`endif
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e      state_q, state_d;
    logic        mem_op, is_store, is_load, misalign, req_ok, stall_int;
    logic [1:0]  a, acc_width;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    logic [31:0] read_data_q, read_data_d, alu_q, alu_d;
    logic [4:0]  rdest_q, rdest_d;
    logic        reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;

    // A store wins when both enables are set.
    assign mem_op    = R_EnableIn | W_EnableIn;
    assign is_store  = W_EnableIn;
    assign is_load   = R_EnableIn & ~W_EnableIn;
    assign a         = ALUResultIn[1:0];
    assign acc_width = is_store ? W_WidthIn : R_WidthIn;

`ifdef MEM_MISALIGN_TRAP_EN
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        misalign = 1'b0;
        if (mem_op) begin
            case (acc_width)
                2'b00:   misalign = (a != 2'b00);
                2'b01:   misalign = a[0];
                2'b11:   misalign = is_store & (a != 2'b00);
                default: misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign req_ok    = mem_op & ~misalign;
    assign stall_int = req_ok & ~DMemAck;
    assign Stall     = Reset & stall_int;

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        DMemReq = 1'b0;
        case (state_q)
            S_IDLE: if (req_ok) begin
                DMemReq = 1'b1;
                if (!DMemAck) state_d = S_WAIT;
            end
            S_WAIT: begin
                DMemReq = 1'b1;
                if (DMemAck) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!Reset) DMemReq = 1'b0;
    end

    assign DMemAddr = {ALUResultIn[31:2], 2'b00};
    assign DMemWe   = DMemReq & is_store;

    always_comb begin
        DMemWData  = RegData2In;
        DMemByteEn = 4'b1111;
        if (is_store) begin
            case (W_WidthIn)
                2'b01: begin
                    DMemWData  = {2{RegData2In[15:0]}};
                    DMemByteEn = a[1] ? 4'b1100 : 4'b0011;
                end
                2'b10: begin
                    DMemWData  = {4{RegData2In[7:0]}};
                    DMemByteEn = 4'b0001 << a;
                end
                default: ;
            endcase
        end
    end

    assign ld_byte = DMemRData[{a, 3'b000} +: 8];
    assign ld_half = a[1] ? DMemRData[31:16] : DMemRData[15:0];

    always_comb begin
        case (R_WidthIn)
            2'b00:   ld_data = DMemRData;
            2'b01:   ld_data = {{16{ld_half[15]}}, ld_half};
            2'b10:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            default: ld_data = {24'b0, ld_byte};
        endcase
    end

    always_comb begin
        PCSrcOut        = 1'b0;
        BranchTargetOut = 32'b0;
        case (BranchSelIn)
            4'b0001: begin PCSrcOut = ZeroIn;  BranchTargetOut = PCPlusBranchIn; end
            4'b0010: begin PCSrcOut = ~ZeroIn; BranchTargetOut = PCPlusBranchIn; end
            4'b0100: begin PCSrcOut = 1'b1; BranchTargetOut = {PCPlusBranchIn[31:28], jumpLeftShiftedTwoIn}; end
            4'b0101: begin PCSrcOut = 1'b1; BranchTargetOut = ALUResultIn; end
            default: ;
        endcase
    end

    // A stall inserts a bubble: controls drop, data fields hold.
    always_comb begin
        read_data_d  = read_data_q;
        alu_d        = alu_q;
        rdest_d      = rdest_q;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        if (!stall_int) begin
            read_data_d  = (is_load & ~misalign) ? ld_data : 32'b0;
            alu_d        = ALUResultIn;
            rdest_d      = rDestSelectedIn;
            reg_write_d  = RegWriteIn & ~misalign;
            mem_to_reg_d = MemToRegIn;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            read_data_q  <= 32'b0;
            alu_q        <= 32'b0;
            rdest_q      <= 5'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            alu_q        <= alu_d;
            rdest_q      <= rdest_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) misalign_q <= 1'b0;
        else        misalign_q <= misalign & ~stall_int;
    end

    assign MisalignOut = misalign_q;
`endif

    assign ReadDataOut      = read_data_q;
    assign ALUResultOut     = alu_q;
    assign rDestSelectedOut = rdest_q;
    assign RegWriteOut      = reg_write_q;
    assign MemToRegOut      = mem_to_reg_q;

endmodule
